// File: rtl/amo_pkg.sv
// AMO opcode encoding and helpers shared by the bank arbiter and the AMO shim.
package amo_pkg;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOCAS  = 4'hA
   } amo_op_t;

   localparam int unsigned DataWidth = 64;
   localparam int unsigned BeWidth   = 8;

   // A single requester still needs a 1-bit index so port widths stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/amo_bank_arbiter_if.sv
// Requester-side and shim-side bundles of the AMO bank arbiter; slave is the arbiter's view.
interface amo_bank_arbiter_if
   import amo_pkg::*;
#(
   parameter int unsigned NumPorts     = 4,
   parameter int unsigned AddrMemWidth = 32
);

   logic [NumPorts-1:0]                        req;
   logic [NumPorts-1:0]                        gnt;
   logic [NumPorts-1:0][AddrMemWidth-1:0]      add;
   amo_op_t [NumPorts-1:0]                     amo;
   logic [NumPorts-1:0]                        wen;
   logic [NumPorts-1:0][DataWidth-1:0]         wdata;
   logic [NumPorts-1:0][BeWidth-1:0]           be;
   logic [NumPorts-1:0]                        rvalid;
   logic [DataWidth-1:0]                       rdata;

   logic                                       out_req;
   logic [AddrMemWidth-1:0]                    out_add;
   amo_op_t                                    out_amo;
   logic                                       out_wen;
   logic [DataWidth-1:0]                       out_wdata;
   logic [BeWidth-1:0]                         out_be;
   logic                                       out_gnt;
   logic [DataWidth-1:0]                       out_rdata;

   modport slave (
      input  req, add, amo, wen, wdata, be, out_gnt, out_rdata,
      output gnt, rvalid, rdata, out_req, out_add, out_amo, out_wen, out_wdata, out_be
   );

   modport master (
      output req, add, amo, wen, wdata, be, out_gnt, out_rdata,
      input  gnt, rvalid, rdata, out_req, out_add, out_amo, out_wen, out_wdata, out_be
   );

endinterface

// File: rtl/amo_rr_arbiter.sv
// Round-robin selector: combinational winner at or after ptr_q, pointer advances past the winner on transfer.
module amo_rr_arbiter
   import amo_pkg::*;
#(
   parameter int unsigned NumPorts = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumPorts-1:0]              req,
   input  logic                             xfer,
   output logic                             sel_vld,
   output logic [idx_width(NumPorts)-1:0]   sel_idx
);

   localparam int unsigned IdxW = idx_width(NumPorts);

   logic [IdxW-1:0] ptr_q;
   logic [IdxW:0]   cand;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (IdxW+1)'(i);
         if (cand >= (IdxW+1)'(NumPorts)) begin
            cand = cand - (IdxW+1)'(NumPorts);
         end
         if (req[cand[IdxW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = cand[IdxW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (xfer) begin
         ptr_q <= (sel_idx == IdxW'(NumPorts - 1)) ? '0 : sel_idx + 1'b1;
      end
   end

endmodule

// File: rtl/amo_bank_arbiter.sv
// Funnels NumPorts requesters into one AMO shim port; grant is same-cycle, response one cycle after transfer.
// out_gnt low holds the selected request and pointer; an AMO blocks all grants during its commit cycle.
module amo_bank_arbiter
   import amo_pkg::*;
#(
   parameter int unsigned NumPorts     = 4,
   parameter int unsigned AddrMemWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   amo_bank_arbiter_if.slave    bus
);

   localparam int unsigned IdxW = idx_width(NumPorts);

   logic                sel_vld;
   logic [IdxW-1:0]     sel_idx;
   logic                xfer;
   logic                amo_busy_q;
   logic [NumPorts-1:0] rvalid_q;

   amo_rr_arbiter #(
      .NumPorts (NumPorts)
   ) u_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (bus.req),
      .xfer    (xfer),
      .sel_vld (sel_vld),
      .sel_idx (sel_idx)
   );

   // Request is gated by reset so nothing leaks out while rst_ni is low.
   always_comb begin
      bus.out_req   = rst_ni & sel_vld & ~amo_busy_q;
      xfer          = bus.out_req & bus.out_gnt;
      bus.gnt       = '0;
      if (xfer) begin
         bus.gnt[sel_idx] = 1'b1;
      end
      bus.out_add   = '0;
      bus.out_amo   = AMONone;
      bus.out_wen   = 1'b0;
      bus.out_wdata = '0;
      bus.out_be    = '0;
      if (sel_vld) begin
         bus.out_add   = bus.add[sel_idx];
         bus.out_amo   = bus.amo[sel_idx];
         bus.out_wen   = bus.wen[sel_idx];
         bus.out_wdata = bus.wdata[sel_idx];
         bus.out_be    = bus.be[sel_idx];
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = (|rvalid_q) ? bus.out_rdata : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q   <= '0;
         amo_busy_q <= 1'b0;
      end else begin
         rvalid_q   <= bus.gnt;
         amo_busy_q <= xfer && (bus.out_amo != AMONone);
      end
   end

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Bench for amo_bank_arbiter: 4-port and 1-port instances, each behind a small behavioural AMO shim.
module tb_amo_bank_arbiter;
   import amo_pkg::*;

   typedef struct {
      int          port;
      logic [63:0] data;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   rsp_t exp_q[$];
   logic [63:0] refm [0:255];

   always #5 clk = ~clk;

   amo_bank_arbiter_if #(.NumPorts(4), .AddrMemWidth(32)) bus ();
   amo_bank_arbiter_if #(.NumPorts(1), .AddrMemWidth(32)) bus1 ();

   amo_bank_arbiter #(.NumPorts(4), .AddrMemWidth(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   amo_bank_arbiter #(.NumPorts(1), .AddrMemWidth(32)) dut1 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus1.slave)
   );

   // Shim: returns the pre-operation word one cycle after a transfer, garbage otherwise.
   logic [63:0] mem  [0:255] = '{default: 64'h0};
   logic [63:0] mem1 [0:255] = '{default: 64'h0};

   always @(posedge clk) begin
      if (bus.out_req && bus.out_gnt) begin
         bus.out_rdata <= mem[bus.out_add[7:0]];
         if (bus.out_amo == AMOAdd)
            mem[bus.out_add[7:0]] <= mem[bus.out_add[7:0]] + bus.out_wdata;
         else if (bus.out_amo == AMOSwap || (bus.out_amo == AMONone && bus.out_wen))
            mem[bus.out_add[7:0]] <= bus.out_wdata;
      end else begin
         bus.out_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   always @(posedge clk) begin
      if (bus1.out_req && bus1.out_gnt) begin
         bus1.out_rdata <= mem1[bus1.out_add[7:0]];
         if (bus1.out_wen) mem1[bus1.out_add[7:0]] <= bus1.out_wdata;
      end else begin
         bus1.out_rdata <= 64'hBAD1_BAD1_BAD1_BAD1;
      end
   end

   task automatic set_port(input int p, input logic r, input logic [31:0] a,
                           input amo_op_t op, input logic w, input logic [63:0] d);
      bus.req[p]   = r;
      bus.add[p]   = a;
      bus.amo[p]   = op;
      bus.wen[p]   = w;
      bus.wdata[p] = d;
      bus.be[p]    = 8'hFF;
   endtask

   task automatic idle_all();
      for (int p = 0; p < 4; p++) set_port(p, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
      bus.out_gnt    = 1'b1;
      bus1.req       = '0;
      bus1.add[0]    = '0;
      bus1.amo[0]    = AMONone;
      bus1.wen       = '0;
      bus1.wdata[0]  = '0;
      bus1.be[0]     = 8'hFF;
      bus1.out_gnt   = 1'b1;
   endtask

   // Reference memory: applies the op port p is presenting and returns the old word.
   task automatic model_xfer(input int p, output logic [63:0] old);
      logic [7:0] a;
      a   = bus.add[p][7:0];
      old = refm[a];
      if (bus.amo[p] == AMOAdd)                          refm[a] = old + bus.wdata[p];
      else if (bus.amo[p] == AMOSwap)                    refm[a] = bus.wdata[p];
      else if (bus.amo[p] == AMONone && bus.wen[p])      refm[a] = bus.wdata[p];
   endtask

   function automatic int oh2i(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic test_reset();
      idle_all();
      rst_n    = 1'b0;
      bus.req  = 4'hF;
      bus1.req = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.gnt !== 4'b0 || bus.out_req !== 1'b0) begin
         n_fail++; $display("FAIL reset_gnt gnt=%b out_req=%b want 0000 0", bus.gnt, bus.out_req);
      end
      n_tests++;
      if (bus.rvalid !== 4'b0 || bus.rdata !== 64'h0) begin
         n_fail++; $display("FAIL reset_rsp rvalid=%b rdata=%h want 0", bus.rvalid, bus.rdata);
      end
      n_tests++;
      if (dut.u_rr.ptr_q !== 2'd0 || dut.amo_busy_q !== 1'b0) begin
         n_fail++; $display("FAIL reset_state ptr=%0d busy=%b want 0 0", dut.u_rr.ptr_q, dut.amo_busy_q);
      end
      n_tests++;
      if (bus1.gnt !== 1'b0 || bus1.out_req !== 1'b0 || bus1.rvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_p1 gnt=%b out_req=%b rvalid=%b want 0", bus1.gnt, bus1.out_req, bus1.rvalid);
      end
      idle_all();
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      n_tests++;
      if (bus.out_req !== 1'b0 || bus.out_add !== 32'h0 || bus.out_wdata !== 64'h0) begin
         n_fail++; $display("FAIL idle_out out_req=%b out_add=%h out_wdata=%h want 0", bus.out_req, bus.out_add, bus.out_wdata);
      end
   endtask

   task automatic test_round_robin();
      int phase [4];
      rsp_t e;
      logic [3:0] exp_rv, exp_g;
      logic [63:0] exp_rd, old;
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
         set_port(p, 1'b1, 32'h20 + p, AMONone, 1'b1, 64'hA0 + p);
         phase[p] = 0;
      end
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         exp_rv = '0; exp_rd = '0;
         if (exp_q.size() != 0) begin e = exp_q.pop_front(); exp_rv[e.port] = 1'b1; exp_rd = e.data; end
         n_tests++;
         if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd) begin
            n_fail++; $display("FAIL rr_rsp c=%0d rvalid=%b rdata=%h want %b %h", c, bus.rvalid, bus.rdata, exp_rv, exp_rd);
         end
         exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
         n_tests++;
         if (bus.gnt !== exp_g) begin
            n_fail++; $display("FAIL rr_gnt c=%0d gnt=%b want %b", c, bus.gnt, exp_g);
         end
         if (c < 8) begin model_xfer(c % 4, old); exp_q.push_back('{port: c % 4, data: old}); end
         @(posedge clk); #1;
         if (c < 8) begin
            phase[c % 4]++;
            if (phase[c % 4] == 1) set_port(c % 4, 1'b1, 32'h20 + (c % 4), AMONone, 1'b0, 64'h0);
            else                   set_port(c % 4, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
         end
      end
   endtask

   task automatic test_amo();
      logic [3:0] eg [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
      rsp_t e;
      logic [3:0] exp_rv;
      logic [63:0] exp_rd, old;
      @(posedge clk); #1;
      set_port(2, 1'b1, 32'h10, AMONone, 1'b1, 64'd5);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_rv = '0; exp_rd = '0;
         if (exp_q.size() != 0) begin e = exp_q.pop_front(); exp_rv[e.port] = 1'b1; exp_rd = e.data; end
         n_tests++;
         if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd) begin
            n_fail++; $display("FAIL amo_rsp c=%0d rvalid=%b rdata=%h want %b %h", c, bus.rvalid, bus.rdata, exp_rv, exp_rd);
         end
         n_tests++;
         if (bus.gnt !== eg[c]) begin
            n_fail++; $display("FAIL amo_gnt c=%0d gnt=%b want %b", c, bus.gnt, eg[c]);
         end
         if (c == 2) begin
            n_tests++;
            if (bus.out_req !== 1'b0) begin
               n_fail++; $display("FAIL amo_busy out_req=%b want 0", bus.out_req);
            end
         end
         if (c == 4) begin
            n_tests++;
            if (mem[8'h10] !== 64'd8) begin
               n_fail++; $display("FAIL amo_mem mem[0x10]=%0d want 8", mem[8'h10]);
            end
         end
         if (eg[c] != 4'b0) begin model_xfer(oh2i(eg[c]), old); exp_q.push_back('{port: oh2i(eg[c]), data: old}); end
         @(posedge clk); #1;
         case (c)
            0: set_port(2, 1'b1, 32'h10, AMOAdd, 1'b0, 64'd3);
            1: begin set_port(2, 1'b0, 32'h0, AMONone, 1'b0, 64'h0); set_port(0, 1'b1, 32'h10, AMONone, 1'b0, 64'h0); end
            3: set_port(0, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
            default: ;
         endcase
      end
   endtask

   task automatic test_rr_skip();
      logic [3:0] eg [4] = '{4'b0100, 4'b1000, 4'b0010, 4'b0000};
      int ep [4] = '{1, 3, 0, 2};
      rsp_t e;
      logic [3:0] exp_rv;
      logic [63:0] exp_rd, old;
      @(posedge clk); #1;
      set_port(2, 1'b1, 32'h20, AMONone, 1'b0, 64'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         exp_rv = '0; exp_rd = '0;
         if (exp_q.size() != 0) begin e = exp_q.pop_front(); exp_rv[e.port] = 1'b1; exp_rd = e.data; end
         n_tests++;
         if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd) begin
            n_fail++; $display("FAIL skip_rsp c=%0d rvalid=%b rdata=%h want %b %h", c, bus.rvalid, bus.rdata, exp_rv, exp_rd);
         end
         n_tests++;
         if (bus.gnt !== eg[c] || dut.u_rr.ptr_q !== 2'(ep[c])) begin
            n_fail++; $display("FAIL skip_gnt c=%0d gnt=%b ptr=%0d want %b %0d", c, bus.gnt, dut.u_rr.ptr_q, eg[c], ep[c]);
         end
         if (eg[c] != 4'b0) begin model_xfer(oh2i(eg[c]), old); exp_q.push_back('{port: oh2i(eg[c]), data: old}); end
         @(posedge clk); #1;
         case (c)
            0: begin
               set_port(2, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
               set_port(1, 1'b1, 32'h21, AMONone, 1'b0, 64'h0);
               set_port(3, 1'b1, 32'h23, AMONone, 1'b0, 64'h0);
            end
            1: set_port(3, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
            2: set_port(1, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
            default: ;
         endcase
      end
   endtask

   task automatic test_stall();
      logic [3:0] eg [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      int ep [5] = '{2, 2, 2, 2, 1};
      rsp_t e;
      logic [3:0] exp_rv;
      logic [63:0] exp_rd, old;
      @(posedge clk); #1;
      bus.out_gnt = 1'b0;
      set_port(0, 1'b1, 32'h23, AMONone, 1'b0, 64'h0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_rv = '0; exp_rd = '0;
         if (exp_q.size() != 0) begin e = exp_q.pop_front(); exp_rv[e.port] = 1'b1; exp_rd = e.data; end
         n_tests++;
         if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd) begin
            n_fail++; $display("FAIL stall_rsp c=%0d rvalid=%b rdata=%h want %b %h", c, bus.rvalid, bus.rdata, exp_rv, exp_rd);
         end
         n_tests++;
         if (bus.gnt !== eg[c] || dut.u_rr.ptr_q !== 2'(ep[c])) begin
            n_fail++; $display("FAIL stall_gnt c=%0d gnt=%b ptr=%0d want %b %0d", c, bus.gnt, dut.u_rr.ptr_q, eg[c], ep[c]);
         end
         if (c < 3) begin
            n_tests++;
            if (bus.out_req !== 1'b1 || bus.out_add !== 32'h23) begin
               n_fail++; $display("FAIL stall_out c=%0d out_req=%b out_add=%h want 1 23", c, bus.out_req, bus.out_add);
            end
         end
         if (eg[c] != 4'b0) begin model_xfer(oh2i(eg[c]), old); exp_q.push_back('{port: oh2i(eg[c]), data: old}); end
         @(posedge clk); #1;
         if (c == 2) bus.out_gnt = 1'b1;
         if (c == 3) set_port(0, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
      end
   endtask

   task automatic test_reset_after_amo();
      logic [63:0] old;
      @(posedge clk); #1;
      set_port(1, 1'b1, 32'h30, AMOAdd, 1'b0, 64'd7);
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++; $display("FAIL rst_amo_gnt gnt=%b want 0010", bus.gnt);
      end
      model_xfer(1, old);
      @(posedge clk); #1;
      set_port(1, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.rvalid !== 4'b0 || bus.rdata !== 64'h0 || bus.out_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_in rvalid=%b rdata=%h out_req=%b want 0", bus.rvalid, bus.rdata, bus.out_req);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.rvalid !== 4'b0 || dut.u_rr.ptr_q !== 2'd0 || dut.amo_busy_q !== 1'b0) begin
         n_fail++; $display("FAIL rst_after rvalid=%b ptr=%0d busy=%b want 0 0 0", bus.rvalid, dut.u_rr.ptr_q, dut.amo_busy_q);
      end
      @(posedge clk); #1;
      set_port(2, 1'b1, 32'h30, AMONone, 1'b0, 64'h0);
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== 4'b0100 || bus.rvalid !== 4'b0) begin
         n_fail++; $display("FAIL rst_new_gnt gnt=%b rvalid=%b want 0100 0000", bus.gnt, bus.rvalid);
      end
      model_xfer(2, old);
      exp_q.push_back('{port: 2, data: old});
      @(posedge clk); #1;
      set_port(2, 1'b0, 32'h0, AMONone, 1'b0, 64'h0);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL rst_new_rsp scoreboard empty, want one entry");
      end else begin
         rsp_t e;
         e = exp_q.pop_front();
         if (bus.rvalid !== 4'(1 << e.port) || bus.rdata !== e.data) begin
            n_fail++; $display("FAIL rst_new_rsp rvalid=%b rdata=%h want %b %h", bus.rvalid, bus.rdata, 4'(1 << e.port), e.data);
         end
      end
   endtask

   task automatic test_single_port();
      logic [63:0] m1, old, exp_rd;
      logic exp_rv;
      rsp_t e;
      m1 = 64'h0;
      @(posedge clk); #1;
      bus1.req      = 1'b1;
      bus1.add[0]   = 32'h4;
      bus1.wen      = 1'b1;
      bus1.wdata[0] = 64'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_rv = 1'b0; exp_rd = '0;
         if (exp_q.size() != 0) begin e = exp_q.pop_front(); exp_rv = 1'b1; exp_rd = e.data; end
         n_tests++;
         if (bus1.rvalid !== exp_rv || bus1.rdata !== exp_rd) begin
            n_fail++; $display("FAIL p1_rsp c=%0d rvalid=%b rdata=%h want %b %h", c, bus1.rvalid, bus1.rdata, exp_rv, exp_rd);
         end
         n_tests++;
         if (bus1.gnt !== ((c < 4) ? 1'b1 : 1'b0) || dut1.u_rr.ptr_q !== 1'b0) begin
            n_fail++; $display("FAIL p1_gnt c=%0d gnt=%b ptr=%0d want %b 0", c, bus1.gnt, dut1.u_rr.ptr_q, (c < 4));
         end
         if (c < 4) begin
            old = m1;
            if (bus1.wen[0]) m1 = bus1.wdata[0];
            exp_q.push_back('{port: 0, data: old});
         end
         @(posedge clk); #1;
         bus1.wen = ~bus1.wen;
         if (c == 3) bus1.req = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) refm[i] = 64'h0;
      test_reset();
      test_round_robin();
      test_amo();
      test_rr_skip();
      test_stall();
      test_reset_after_amo();
      test_single_port();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish within 100000 time units");
      $fatal(1);
   end

endmodule
